// File: rtl/cnt_arb_pkg.sv
// Shared types and default geometry for the two-band run-counter arbiter.
package cnt_arb_pkg;

  localparam int unsigned CNT_W   = 7;
  localparam int unsigned LO_BASE = 0;
  localparam int unsigned HI_BASE = 50;
  localparam int unsigned SPAN    = 50;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cnt_band_counter.sv
// Loadable band counter: steps from base, wraps at base+SPAN-1, tracks remaining values.
module cnt_band_counter #(
  parameter int unsigned CNT_W = 7,
  parameter int unsigned SPAN  = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] base,
  input  logic [CNT_W-1:0] len,
  input  logic             step,
  output logic [CNT_W-1:0] value,
  output logic             last,
  output logic             empty
);

  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] base_r;
  logic [CNT_W-1:0] wrap_at;

  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= '0;
      remaining <= '0;
      base_r    <= '0;
      wrap_at   <= '0;
    end else if (load) begin
      remaining <= len;
      base_r    <= base;
      wrap_at   <= base + CNT_W'(SPAN - 1);
      // A zero-length run emits nothing, so the visible value is left alone.
      if (len != '0) value <= base;
    end else if (step) begin
      remaining <= remaining - 1'b1;
      value     <= (value == wrap_at) ? base_r : value + 1'b1;
    end
  end

  assign last  = (remaining == CNT_W'(1));
  assign empty = (remaining == '0);

endmodule

// File: rtl/cnt_run_arbiter.sv
// Round-robin arbiter sharing one band counter between two requesters.
// Optional: define CNT_ARB_PIPE_OUT_EN to add one register stage on the counter/done outputs.
module cnt_run_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int unsigned CNT_W   = cnt_arb_pkg::CNT_W,
  parameter int unsigned LO_BASE = cnt_arb_pkg::LO_BASE,
  parameter int unsigned HI_BASE = cnt_arb_pkg::HI_BASE,
  parameter int unsigned SPAN    = cnt_arb_pkg::SPAN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_vld,
  output logic             done,
  output logic             done_id,
  output logic             aborted
);

  state_t state, state_n;
  logic   id_r, last_srv, aborted_r;

  logic             grant, grant_id, load, step, abort_hit;
  logic [CNT_W-1:0] base_sel, len_sel;
  logic [CNT_W-1:0] value;
  logic             last, empty;

  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    grant_id  = id_r;
    step      = 1'b0;
    abort_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant   = 1'b1;
          state_n = RUN;
          case (req)
            2'b01:   grant_id = REQ0;
            2'b10:   grant_id = REQ1;
            default: grant_id = (last_srv == REQ0) ? REQ1 : REQ0;
          endcase
        end
      end
      RUN: begin
        // An empty run spends its single granted cycle here without a valid value.
        if (empty || last || abort) begin
          state_n   = DONE;
          abort_hit = abort && !last && !empty;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign load     = grant;
  assign base_sel = grant_id ? CNT_W'(HI_BASE) : CNT_W'(LO_BASE);
  assign len_sel  = grant_id ? len1 : len0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id_r      <= REQ0;
      last_srv  <= REQ1;
      aborted_r <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) id_r <= grant_id;
      if (state == RUN && state_n == DONE) aborted_r <= abort_hit;
      if (state == DONE) last_srv <= id_r;
    end
  end

  cnt_band_counter #(
    .CNT_W (CNT_W),
    .SPAN  (SPAN)
  ) u_band (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .base  (base_sel),
    .len   (len_sel),
    .step  (step),
    .value (value),
    .last  (last),
    .empty (empty)
  );

  logic             vld_c, done_c, aborted_c;

  assign gnt       = (state == RUN) ? (id_r ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);
  assign vld_c     = (state == RUN) && !empty;
  assign done_c    = (state == DONE);
  assign aborted_c = done_c && aborted_r;

`ifdef CNT_ARB_PIPE_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out <= '0;
      cnt_vld <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      aborted <= 1'b0;
    end else begin
      cnt_out <= value;
      cnt_vld <= vld_c;
      done    <= done_c;
      done_id <= id_r;
      aborted <= aborted_c;
    end
  end
`else
  assign cnt_out = value;
  assign cnt_vld = vld_c;
  assign done    = done_c;
  assign done_id = id_r;
  assign aborted = aborted_c;
`endif

endmodule

// File: tb/tb_cnt_run_arbiter.sv
// Directed self-checking bench for cnt_run_arbiter (default build, latency 1).
module tb_cnt_run_arbiter;

  localparam int unsigned CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [CNT_W-1:0] len0 = '0;
  logic [CNT_W-1:0] len1 = '0;
  logic             abort = 1'b0;
  logic [1:0]       gnt;
  logic             busy;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_vld;
  logic             done;
  logic             done_id;
  logic             aborted;

  int checks = 0;
  int errors = 0;

  cnt_run_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len0    (len0),
    .len1    (len1),
    .abort   (abort),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_out (cnt_out),
    .cnt_vld (cnt_vld),
    .done    (done),
    .done_id (done_id),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 2'b00;
    abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt_out), 0);
    chk("rst_vld", 32'(cnt_vld), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_aborted", 32'(aborted), 0);
  endtask

  // Request must already be driven; returns one cycle after DONE (back in IDLE).
  task automatic do_run(input int who, input int len, input int abort_idx);
    int base;
    int n;
    int lastv;
    logic [1:0] g;
    logic exp_ab;
    base   = (who != 0) ? 50 : 0;
    g      = (who != 0) ? 2'b10 : 2'b01;
    exp_ab = (abort_idx >= 0) && (abort_idx < len - 1);
    lastv  = 0;
    tick();
    if (len == 0) begin
      chk("z_gnt", 32'(gnt), 32'(g));
      chk("z_vld", 32'(cnt_vld), 0);
      chk("z_busy", 32'(busy), 1);
      tick();
    end else begin
      n = (abort_idx >= 0 && abort_idx < len) ? abort_idx + 1 : len;
      for (int i = 0; i < n; i++) begin
        chk("run_gnt", 32'(gnt), 32'(g));
        chk("run_vld", 32'(cnt_vld), 1);
        chk("run_cnt", 32'(cnt_out), 32'(base + (i % 50)));
        chk("run_done", 32'(done), 0);
        if (i == abort_idx) abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      lastv = base + ((n - 1) % 50);
    end
    chk("dn_done", 32'(done), 1);
    chk("dn_id", 32'(done_id), 32'(who));
    chk("dn_aborted", 32'(aborted), 32'(exp_ab));
    chk("dn_gnt", 32'(gnt), 0);
    chk("dn_vld", 32'(cnt_vld), 0);
    chk("dn_busy", 32'(busy), 1);
    if (len > 0) chk("dn_hold", 32'(cnt_out), 32'(lastv));
    req[who] = 1'b0;
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_gnt", 32'(gnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // single requester, short run
    req = 2'b01; len0 = 7'd3;
    do_run(0, 3, -1);

    // contention after reset: 0 first, then 1; then 0 again after 1 was served
    do_reset();
    req = 2'b11; len0 = 7'd2; len1 = 7'd2;
    do_run(0, 2, -1);
    do_run(1, 2, -1);
    req = 2'b11; len0 = 7'd1; len1 = 7'd1;
    do_run(0, 1, -1);
    do_run(1, 1, -1);

    // long run wrapping the high band
    req = 2'b10; len1 = 7'd55;
    do_run(1, 55, -1);

    // abort mid-run, then abort on the final value
    req = 2'b01; len0 = 7'd10;
    do_run(0, 10, 3);
    req = 2'b01;
    do_run(0, 10, 9);

    // zero-length run
    req = 2'b01; len0 = 7'd0;
    do_run(0, 0, -1);

    // reset mid-run, then arbitration must favour requester 0 again
    req = 2'b01; len0 = 7'd10;
    tick();
    repeat (5) tick();
    chk("mid_cnt", 32'(cnt_out), 5);
    rst = 1'b1;
    tick();
    chk("mr_gnt", 32'(gnt), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_cnt", 32'(cnt_out), 0);
    chk("mr_vld", 32'(cnt_vld), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_aborted", 32'(aborted), 0);
    rst = 1'b0;
    req = 2'b11; len0 = 7'd2; len1 = 7'd2;
    do_run(0, 2, -1);
    do_run(1, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
